jtopll_mmr_wr: RTL and testbench
================================

// Module: jtopll_mmr_wr
// PURPOSE
//  CPU-side write decoder for the OPLL register file. Turns the two-port chip bus
//  (address port / data port) into the update strobes, group/subslot selection and
//  data byte that the register file consumes. Holds each channel update for one full
//  slot round so that it lands when the slot counter matches the selected channel.
//  Also owns the rhythm control register and drives rhy_en/rhy_kon.
// PARAMETERS
//  HOLD      18   cen ticks an update strobe stays asserted (one full slot round)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous reset, active high
//  cen          in   1  clock enable, same enable the register file uses
//  din          in   8  CPU data bus
//  addr         in   1  0 = address port, 1 = data port
//  cs_n         in   1  chip select, active low
//  wr_n         in   1  write strobe, active low
//  reg_din      out  8  data byte to register file
//  sel_group    out  2  channel group of pending update (ch/3)
//  sel_sub      out  3  subslot of pending update (ch%3)
//  up_fnumlo    out  1  update fnum[7:0]        (regs 0x10-0x18)
//  up_fnumhi    out  1  update sus/kon/blk/fnum8 (regs 0x20-0x28)
//  up_inst      out  1  update inst/vol          (regs 0x30-0x38)
//  up_original  out  1  update user patch byte   (regs 0x00-0x07, byte = sel_sub)
//  rhy_en       out  1  rhythm mode enable (reg 0x0E bit 5)
//  rhy_kon      out  5  rhythm key-on BD,SD,TOM,CYM,HH (reg 0x0E bits 4:0)
//  busy         out  1  high while an update is being held
// BEHAVIOUR
//  Reset: all outputs 0, latched address 0, state IDLE, hold counter 0. Reset is
//   asynchronous; asserting it mid-hold drops the pending update.
//  Write detect: write = !cs_n & !wr_n sampled on clk, registered; a write event is the
//   first clk with write=1 after write=0. Holding wr_n low yields one event. Events are
//   detected on every clk regardless of cen.
//  Address port event (addr=0): latch din as register number; accepted in any state.
//  Data port event (addr=1), decoded from latched address, registered next clk:
//   0x00-0x07: sel_sub=addr[2:0], sel_group=0, up_original=1, reg_din=din -> HOLD
//   0x0E: rhy_en<=din[5], rhy_kon<=din[4:0] on next clk; no hold, state unchanged
//   0x10-0x18 / 0x20-0x28 / 0x30-0x38: ch=addr[3:0]; sel_group=ch/3, sel_sub=ch%3,
//    matching up_* =1, reg_din=din -> HOLD
//   anything else (0x08-0x0D, 0x0F, ch 9-15, 0x39+): ignored, no output change
//  FSM: IDLE -> HOLD on accepted channel/patch write; counter cleared.
//   HOLD: counter increments on each cen; when counter==HOLD-1 and cen: all up_* <=0,
//   -> IDLE. busy = (state==HOLD). reg_din/sel_* remain stable during whole HOLD.
//  Data write during HOLD to a channel/patch register: dropped (matches real chip losing
//   too-fast writes); write to 0x0E during HOLD is still applied.
//  Exactly one up_* is high at any time; none high in IDLE.
//  cen held low: HOLD lasts indefinitely; strobes stay asserted.
// TESTING
//  1 reset, write addr 0x10 then data 0x55 -> next clk up_fnumlo=1,sel_group=0,
//    sel_sub=0,reg_din=0x55; stays 18 cen ticks; then 0, busy=0
//  2 addr 0x37 data 0xA3 -> up_inst=1, sel_group=2, sel_sub=1, reg_din=0xA3
//  3 addr 0x05 data 0x7F -> up_original=1, sel_sub=5; addr 0x19 data 0x12 -> no strobe
//  4 during HOLD of 0x21 write 0x31/0x40 -> dropped; write 0x0E=0x3F -> rhy_en=1,
//    rhy_kon=0x1F immediately, original hold unaffected
//  5 wr_n held low 50 clks on data port -> single event, single HOLD period
//  6 assert rst at hold tick 7 -> all outputs 0 asynchronously, busy=0 after release

Source files
------------

// File: rtl/jtopll_mmr_wr.sv
// CPU-side write decoder for the OPLL register file: turns address/data port writes
// into held update strobes, group/subslot selection and the rhythm control register.
module jtopll_mmr_wr #(
  parameter int HOLD = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       addr,
  input  logic       cs_n,
  input  logic       wr_n,
  output logic [7:0] reg_din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_inst,
  output logic       up_original,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic       busy
);

  localparam int CW = $clog2(HOLD);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q;
  logic [7:0]    addr_q, addr_d;
  logic [3:0]    up_q, up_d;          // {fnumlo, fnumhi, inst, original}
  logic [7:0]    reg_din_q, reg_din_d;
  logic [1:0]    group_q, group_d;
  logic [2:0]    sub_q, sub_d;
  logic          rhy_en_q, rhy_en_d;
  logic [4:0]    rhy_kon_q, rhy_kon_d;

  logic       write_now, wr_event;
  logic [3:0] ch;
  logic       ch_ok, is_patch, is_rhy, is_fnlo, is_fnhi, is_inst;
  logic [1:0] ch_group;
  logic [2:0] ch_sub;

  // Holding wr_n low yields one event: only the 0->1 transition of the write level counts.
  assign write_now = !cs_n && !wr_n;
  assign wr_event  = write_now && !write_q;

  assign ch       = addr_q[3:0];
  assign ch_ok    = ch <= 4'd8;
  assign is_patch = addr_q[7:3] == 5'd0;
  assign is_rhy   = addr_q == 8'h0E;
  assign is_fnlo  = (addr_q[7:4] == 4'h1) && ch_ok;
  assign is_fnhi  = (addr_q[7:4] == 4'h2) && ch_ok;
  assign is_inst  = (addr_q[7:4] == 4'h3) && ch_ok;

  always_comb begin
    ch_group = 2'd0;
    ch_sub   = 3'd0;
    case (ch)
      4'd0: begin ch_group = 2'd0; ch_sub = 3'd0; end
      4'd1: begin ch_group = 2'd0; ch_sub = 3'd1; end
      4'd2: begin ch_group = 2'd0; ch_sub = 3'd2; end
      4'd3: begin ch_group = 2'd1; ch_sub = 3'd0; end
      4'd4: begin ch_group = 2'd1; ch_sub = 3'd1; end
      4'd5: begin ch_group = 2'd1; ch_sub = 3'd2; end
      4'd6: begin ch_group = 2'd2; ch_sub = 3'd0; end
      4'd7: begin ch_group = 2'd2; ch_sub = 3'd1; end
      4'd8: begin ch_group = 2'd2; ch_sub = 3'd2; end
      default: begin ch_group = 2'd0; ch_sub = 3'd0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    up_d      = up_q;
    reg_din_d = reg_din_q;
    group_d   = group_q;
    sub_d     = sub_q;
    rhy_en_d  = rhy_en_q;
    rhy_kon_d = rhy_kon_q;

    if (wr_event && !addr) addr_d = din;

    if (wr_event && addr) begin
      if (is_rhy) begin
        rhy_en_d  = din[5];
        rhy_kon_d = din[4:0];
      end else if (state_q == ST_IDLE && (is_patch || is_fnlo || is_fnhi || is_inst)) begin
        state_d   = ST_HOLD;
        cnt_d     = '0;
        reg_din_d = din;
        up_d      = {is_fnlo, is_fnhi, is_inst, is_patch};
        group_d   = is_patch ? 2'd0 : ch_group;
        sub_d     = is_patch ? addr_q[2:0] : ch_sub;
      end
    end

    // The strobe spans one full slot round so every slot sees it once.
    if (state_q == ST_HOLD && cen) begin
      if (cnt_q == CW'(HOLD - 1)) begin
        state_d = ST_IDLE;
        up_d    = 4'd0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      addr_q    <= 8'd0;
      up_q      <= 4'd0;
      reg_din_q <= 8'd0;
      group_q   <= 2'd0;
      sub_q     <= 3'd0;
      rhy_en_q  <= 1'b0;
      rhy_kon_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      write_q   <= write_now;
      addr_q    <= addr_d;
      up_q      <= up_d;
      reg_din_q <= reg_din_d;
      group_q   <= group_d;
      sub_q     <= sub_d;
      rhy_en_q  <= rhy_en_d;
      rhy_kon_q <= rhy_kon_d;
    end
  end

  assign reg_din     = reg_din_q;
  assign sel_group   = group_q;
  assign sel_sub     = sub_q;
  assign up_fnumlo   = up_q[3];
  assign up_fnumhi   = up_q[2];
  assign up_inst     = up_q[1];
  assign up_original = up_q[0];
  assign rhy_en      = rhy_en_q;
  assign rhy_kon     = rhy_kon_q;
  assign busy        = state_q == ST_HOLD;

endmodule

// File: tb/tb_jtopll_mmr_wr.sv
// Bench for jtopll_mmr_wr: directed scenarios plus random bus traffic against a
// transaction-level model of the register write decoder.
module tb_jtopll_mmr_wr;

  localparam int HOLD = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cen = 1'b1;
  logic [7:0] din = 8'd0;
  logic       addr = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] reg_din;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic       up_fnumlo, up_fnumhi, up_inst, up_original, rhy_en, busy;
  logic [4:0] rhy_kon;

  jtopll_mmr_wr #(.HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .cen(cen), .din(din), .addr(addr), .cs_n(cs_n), .wr_n(wr_n),
    .reg_din(reg_din), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi), .up_inst(up_inst),
    .up_original(up_original), .rhy_en(rhy_en), .rhy_kon(rhy_kon), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] dut_vec;
  assign dut_vec = {reg_din, sel_group, sel_sub, up_fnumlo, up_fnumhi, up_inst,
                    up_original, rhy_en, rhy_kon, busy};

  // Reference model: pending update with a count of cen ticks still to go.
  bit         cen_rand = 1'b0;
  bit         m_prev;
  logic [7:0] m_addr, m_din;
  logic [1:0] m_grp;
  logic [2:0] m_sub;
  logic [3:0] m_up;
  bit         m_rhy_en;
  logic [4:0] m_kon;
  int         m_left;

  function automatic logic [23:0] model_vec();
    return {m_din, m_grp, m_sub, m_up, m_rhy_en, m_kon, (m_left > 0) ? 1'b1 : 1'b0};
  endfunction

  task automatic model_reset();
    m_prev = 0; m_addr = 0; m_din = 0; m_grp = 0; m_sub = 0; m_up = 0;
    m_rhy_en = 0; m_kon = 0; m_left = 0;
  endtask

  task automatic model_step();
    bit w, ev, was_busy;
    int ch, kind;
    w = !cs_n && !wr_n;
    ev = w && !m_prev;
    m_prev = w;
    was_busy = m_left > 0;
    if (was_busy && cen) begin
      m_left--;
      if (m_left == 0) m_up = 0;
    end
    if (ev && !addr) m_addr = din;
    else if (ev) begin
      ch = int'(m_addr) % 16;
      kind = int'(m_addr) / 16;
      if (m_addr == 8'h0E) begin
        m_rhy_en = din[5];
        m_kon = din[4:0];
      end else if (!was_busy) begin
        if (m_addr < 8) begin
          m_up = 4'b0001; m_grp = 0; m_sub = m_addr[2:0]; m_din = din; m_left = HOLD;
        end else if (kind >= 1 && kind <= 3 && ch < 9) begin
          m_up = 4'b1000 >> (kind - 1);
          m_grp = 2'(ch / 3); m_sub = 3'(ch % 3); m_din = din; m_left = HOLD;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    cen = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic bus_write(input logic port, input logic [7:0] d, input int n);
    cs_n = 1'b0; wr_n = 1'b0; addr = port; din = d;
    repeat (n) cycle();
    cs_n = 1'b1; wr_n = 1'b1; din = 8'($urandom);
    cycle();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL reset_async got %h expected %h", dut_vec, 24'h0);
    end
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_release got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_fnumlo();
    int hi;
    cen_rand = 0;
    bus_write(1'b0, 8'h10, 1);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h55;
    cycle();
    checks++;
    if ({up_fnumlo, up_fnumhi, up_inst, up_original, sel_group, sel_sub, reg_din, busy}
        !== {4'b1000, 2'd0, 3'd0, 8'h55, 1'b1}) begin
      errors++; $display("FAIL fnumlo_strobe got %h expected %h", dut_vec, model_vec());
    end
    cs_n = 1'b1; wr_n = 1'b1;
    hi = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      cycle();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL fnumlo_hold got %h expected %h", dut_vec, model_vec());
      end
      if (up_fnumlo) hi++;
    end
    checks++;
    if (hi !== HOLD || busy !== 1'b0) begin
      errors++; $display("FAIL fnumlo_length got %0d busy %b expected %0d busy 0", hi, busy, HOLD);
    end
  endtask

  task automatic test_inst();
    cen_rand = 1;
    bus_write(1'b0, 8'h37, 1);
    bus_write(1'b1, 8'hA3, 1);
    checks++;
    if ({up_fnumlo, up_fnumhi, up_inst, up_original, sel_group, sel_sub, reg_din}
        !== {4'b0010, 2'd2, 3'd1, 8'hA3}) begin
      errors++; $display("FAIL inst_strobe got %h expected %h", dut_vec, model_vec());
    end
    for (int i = 0; i < 200 && m_left > 0; i++) begin
      cycle();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL inst_hold got %h expected %h", dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_patch_ignored();
    logic [7:0] bad [9];
    bad = '{8'h08, 8'h0D, 8'h0F, 8'h19, 8'h1F, 8'h29, 8'h39, 8'h40, 8'hFF};
    cen_rand = 1;
    bus_write(1'b0, 8'h05, 1);
    bus_write(1'b1, 8'h7F, 1);
    checks++;
    if ({up_fnumlo, up_fnumhi, up_inst, up_original, sel_group, sel_sub, reg_din}
        !== {4'b0001, 2'd0, 3'd5, 8'h7F}) begin
      errors++; $display("FAIL patch_strobe got %h expected %h", dut_vec, model_vec());
    end
    for (int i = 0; i < 200 && m_left > 0; i++) cycle();
    checks++;
    if (dut_vec !== model_vec()) begin
      errors++; $display("FAIL patch_end got %h expected %h", dut_vec, model_vec());
    end
    foreach (bad[i]) begin
      bus_write(1'b0, bad[i], 1);
      bus_write(1'b1, 8'($urandom), 1);
      checks++;
      if (dut_vec !== model_vec() || busy !== 1'b0) begin
        errors++; $display("FAIL ignored_%h got %h expected %h", bad[i], dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_drop_during_hold();
    cen_rand = 1;
    bus_write(1'b0, 8'h21, 1);
    bus_write(1'b1, 8'h9C, 1);
    bus_write(1'b0, 8'h31, 1);
    bus_write(1'b1, 8'h40, 1);
    checks++;
    if ({up_fnumhi, up_inst, sel_group, sel_sub, reg_din, busy} !== {2'b10, 2'd0, 3'd1, 8'h9C, 1'b1}) begin
      errors++; $display("FAIL drop_write got %h expected %h", dut_vec, model_vec());
    end
    bus_write(1'b0, 8'h0E, 1);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h3F;
    cycle();
    checks++;
    if ({rhy_en, rhy_kon, up_fnumhi, reg_din} !== {1'b1, 5'h1F, 1'b1, 8'h9C}) begin
      errors++; $display("FAIL rhythm_in_hold got %h expected %h", dut_vec, model_vec());
    end
    cs_n = 1'b1; wr_n = 1'b1;
    for (int i = 0; i < 200 && m_left > 0; i++) begin
      cycle();
      checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL drop_hold got %h expected %h", dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_wr_held();
    int rises, hi;
    bit prev_busy;
    cen_rand = 0;
    rises = 0; hi = 0; prev_busy = busy;
    bus_write(1'b0, 8'h12, 1);
    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h66;
    for (int i = 0; i < 80; i++) begin
      if (i == 50) begin cs_n = 1'b1; wr_n = 1'b1; end
      cycle();
      if (busy && !prev_busy) rises++;
      if (up_fnumlo) hi++;
      prev_busy = busy;
    end
    checks++;
    if (rises !== 1 || hi !== HOLD) begin
      errors++; $display("FAIL wr_held got %0d events %0d high expected 1 events %0d high", rises, hi, HOLD);
    end
  endtask

  task automatic test_reset_mid_hold();
    int ticks;
    cen_rand = 1;
    bus_write(1'b0, 8'h34, 1);
    bus_write(1'b1, 8'hC5, 1);
    ticks = HOLD - m_left;
    for (int i = 0; i < 200 && ticks < 7; i++) begin
      cycle();
      ticks = HOLD - m_left;
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 24'h0) begin
      errors++; $display("FAIL reset_mid_hold got %h expected %h", dut_vec, 24'h0);
    end
    cycle();
    rst = 1'b0;
    cycle(); cycle();
    checks++;
    if (busy !== 1'b0 || dut_vec !== model_vec()) begin
      errors++; $display("FAIL reset_after got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    cen_rand = 1;
    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'h0E : 8'($urandom_range(0, 63));
      bus_write(1'b0, a, $urandom_range(1, 2));
      bus_write(1'b1, 8'($urandom), $urandom_range(1, 3));
      exp_q.push_back(model_vec());
      checks++;
      if (dut_vec !== exp_q[0]) begin
        errors++; $display("FAIL random_wr_%h got %h expected %h", a, dut_vec, exp_q[0]);
      end
      void'(exp_q.pop_front());
      repeat ($urandom_range(0, 20)) begin
        cycle();
        checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL random_gap got %h expected %h", dut_vec, model_vec());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fnumlo();
    test_inst();
    test_patch_ignored();
    test_drop_during_hold();
    test_wr_held();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
